// File: rtl/iwm_sequencer.sv
// Command-driven sequencer that owns the IWM host access port: SETBIT, WRITE-N and READ-N
// commands are turned into timed /DEVSEL accesses with handshake/MSB polling.
module iwm_sequencer #(
    parameter int          ACCESS_CYCLES = 4,
    parameter int          GAP_CYCLES    = 2,
    parameter logic [15:0] TIMEOUT_POLLS = 16'd40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [9:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       done,
    output logic [1:0] err,
    output logic       busy,
    output logic [3:0] iwm_addr,
    output logic       iwm_devsel_n,
    output logic [7:0] iwm_dout,
    input  logic [7:0] iwm_din
);

    localparam logic [3:0] S_IDLE  = 4'd0,  S_SET   = 4'd1,  W_WAIT = 4'd2,  W_Q6   = 4'd3,
                           W_Q7    = 4'd4,  W_POLL  = 4'd5,  W_DRAIN = 4'd6, W_END  = 4'd7,
                           R_Q7    = 4'd8,  R_Q6    = 4'd9,  R_POLL = 4'd10, R_PUSH = 4'd11,
                           S_DONE  = 4'd12;

    localparam logic [1:0] A_IDLE = 2'd0, A_SETUP = 2'd1, A_LOW = 2'd2, A_GAP = 2'd3;

    localparam int             CNT_MAX  = (ACCESS_CYCLES > GAP_CYCLES) ? ACCESS_CYCLES : GAP_CYCLES;
    localparam int             CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  LOW_LAST = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYCLES - 1);

    logic [3:0]    state;
    logic [1:0]    acc_phase;
    logic [CW-1:0] acc_cnt;
    logic [7:0]    acc_rdata;
    logic [9:0]    remain;
    logic [15:0]   poll_cnt;
    logic [1:0]    err_pend;

    logic          acc_done;
    logic [15:0]   poll_next;
    logic          poll_expired;

    assign acc_done     = (acc_phase == A_GAP) && (acc_cnt == GAP_LAST);
    assign poll_next    = poll_cnt + 16'd1;
    assign poll_expired = (poll_next == TIMEOUT_POLLS);

    // NOTE: cmd_ready includes reset so no command is taken in the reset cycle itself.
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    // NOTE: every register here uses non-blocking assignment; the access engine is written
    // before the FSM so an FSM-issued access start overrides the engine's return to A_IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            acc_phase    <= A_IDLE;
            acc_cnt      <= '0;
            acc_rdata    <= 8'h00;
            remain       <= 10'd0;
            poll_cnt     <= 16'd0;
            err_pend     <= 2'b00;
            wr_ready     <= 1'b0;
            rd_data      <= 8'h00;
            rd_valid     <= 1'b0;
            done         <= 1'b0;
            err          <= 2'b00;
            iwm_addr     <= 4'h0;
            iwm_devsel_n <= 1'b1;
            iwm_dout     <= 8'h00;
        end else begin
            wr_ready <= 1'b0;
            done     <= 1'b0;

            // Access engine: one setup cycle, ACCESS_CYCLES low, GAP_CYCLES high.
            case (acc_phase)
                A_SETUP: begin
                    acc_phase    <= A_LOW;
                    acc_cnt      <= '0;
                    iwm_devsel_n <= 1'b0;
                end
                A_LOW: begin
                    if (acc_cnt == LOW_LAST) begin
                        acc_phase    <= A_GAP;
                        acc_cnt      <= '0;
                        iwm_devsel_n <= 1'b1;
                        acc_rdata    <= iwm_din;
                    end else begin
                        acc_cnt <= acc_cnt + CW'(1);
                    end
                end
                A_GAP: begin
                    if (acc_done) acc_phase <= A_IDLE;
                    else          acc_cnt   <= acc_cnt + CW'(1);
                end
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        remain   <= cmd_len;
                        poll_cnt <= 16'd0;
                        err_pend <= 2'b00;
                        if (cmd_op == 2'b01 || cmd_op == 2'b10) begin
                            if (cmd_len == 10'd0) begin
                                state <= S_DONE; done <= 1'b1; err <= 2'b00;
                            end else if (cmd_op == 2'b01) begin
                                state <= W_WAIT;
                            end else begin
                                state <= R_Q7; acc_phase <= A_SETUP; iwm_addr <= 4'hE; iwm_dout <= 8'h00;
                            end
                        end else begin
                            state <= S_SET; acc_phase <= A_SETUP; iwm_addr <= cmd_addr; iwm_dout <= 8'h00;
                        end
                    end
                end
                S_SET: if (acc_done) begin
                    state <= S_DONE; done <= 1'b1; err <= 2'b00;
                end
                W_WAIT: if (wr_valid) begin
                    state <= W_Q6; acc_phase <= A_SETUP; iwm_addr <= 4'hD; iwm_dout <= 8'h00;
                end
                W_Q6: if (acc_done) begin
                    state <= W_Q7; acc_phase <= A_SETUP; iwm_addr <= 4'hF; iwm_dout <= wr_data;
                end
                W_Q7: if (acc_done) begin
                    wr_ready <= 1'b1;
                    remain   <= remain - 10'd1;
                    state <= W_POLL; acc_phase <= A_SETUP; iwm_addr <= 4'hC; iwm_dout <= 8'h00;
                end
                W_POLL: if (acc_done) begin
                    if (!acc_rdata[6]) begin
                        err_pend <= 2'b10;
                        state <= W_END; acc_phase <= A_SETUP; iwm_addr <= 4'hE;
                    end else if (!acc_rdata[7]) begin
                        if (poll_expired) begin
                            err_pend <= 2'b01;
                            state <= W_END; acc_phase <= A_SETUP; iwm_addr <= 4'hE;
                        end else begin
                            poll_cnt <= poll_next; acc_phase <= A_SETUP;
                        end
                    end else begin
                        poll_cnt <= 16'd0;
                        if (remain != 10'd0) state <= W_WAIT;
                        else begin
                            state <= W_DRAIN; acc_phase <= A_SETUP;
                        end
                    end
                end
                // Last nibble loaded: one more bit7=1 poll proves the shifter took it.
                W_DRAIN: if (acc_done) begin
                    if (acc_rdata[7]) begin
                        state <= W_END; acc_phase <= A_SETUP; iwm_addr <= 4'hE;
                    end else if (poll_expired) begin
                        err_pend <= 2'b01;
                        state <= W_END; acc_phase <= A_SETUP; iwm_addr <= 4'hE;
                    end else begin
                        poll_cnt <= poll_next; acc_phase <= A_SETUP;
                    end
                end
                W_END: if (acc_done) begin
                    state <= S_DONE; done <= 1'b1; err <= err_pend;
                end
                R_Q7: if (acc_done) begin
                    state <= R_Q6; acc_phase <= A_SETUP; iwm_addr <= 4'hC;
                end
                R_Q6: if (acc_done) begin
                    state <= R_POLL; acc_phase <= A_SETUP; iwm_addr <= 4'hC;
                end
                R_POLL: if (acc_done) begin
                    if (acc_rdata[7]) begin
                        rd_data  <= acc_rdata;
                        rd_valid <= 1'b1;
                        poll_cnt <= 16'd0;
                        state    <= R_PUSH;
                    end else if (poll_expired) begin
                        state <= S_DONE; done <= 1'b1; err <= 2'b01;
                    end else begin
                        poll_cnt <= poll_next; acc_phase <= A_SETUP;
                    end
                end
                R_PUSH: if (rd_ready) begin
                    rd_valid <= 1'b0;
                    remain   <= remain - 10'd1;
                    if (remain == 10'd1) begin
                        state <= S_DONE; done <= 1'b1; err <= 2'b00;
                    end else begin
                        state <= R_POLL; acc_phase <= A_SETUP; iwm_addr <= 4'hC;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iwm_sequencer.sv
// Directed bench for iwm_sequencer: a small IWM responder drives iwm_din and a monitor logs
// every /DEVSEL low window (address, data, length, setup/stability) for the tests to inspect.
module tb_iwm_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_addr = 4'h0;
    logic [9:0] cmd_len = 10'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       done;
    logic [1:0] err;
    logic       busy;
    logic [3:0] iwm_addr;
    logic       iwm_devsel_n;
    logic [7:0] iwm_dout;
    logic [7:0] iwm_din;

    always #5 clk = ~clk;

    iwm_sequencer #(
        .ACCESS_CYCLES(4),
        .GAP_CYCLES(2),
        .TIMEOUT_POLLS(16'd16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err), .busy(busy),
        .iwm_addr(iwm_addr), .iwm_devsel_n(iwm_devsel_n),
        .iwm_dout(iwm_dout), .iwm_din(iwm_din)
    );

    int checks = 0;
    int errors = 0;

    // IWM responder: 0 handshake model, 1 underrun, 2 scripted read, 3 idle bus, 4 data always ready
    int         mode = 3;
    logic       hs_ready = 1'b1;
    logic [7:0] rd_script [8];
    int         rd_base = 0;
    int         rd_idx;

    // Window log, written only by the monitor
    logic [3:0] log_addr [$];
    logic [7:0] log_dout [$];
    int         log_len  [$];
    bit         log_ok   [$];
    int         win_cnt = 0;
    int         low_run = 0;
    logic [3:0] cur_addr, prev_addr = 4'h0;
    logic [7:0] cur_dout, prev_dout = 8'h00;
    bit         cur_ok;
    int         wr_pulses = 0, done_pulses = 0, rd_hs = 0;

    assign rd_idx = win_cnt - rd_base;

    always_comb begin
        iwm_din = 8'h00;
        case (mode)
            0: iwm_din = hs_ready ? 8'hC0 : 8'h40;
            2: if (rd_idx >= 0 && rd_idx < 8) iwm_din = rd_script[rd_idx];
            4: iwm_din = 8'h80;
            default: iwm_din = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (!iwm_devsel_n) begin
            if (low_run == 0) begin
                cur_addr = iwm_addr;
                cur_dout = iwm_dout;
                cur_ok   = (iwm_addr == prev_addr) && (iwm_dout == prev_dout);
            end else if (iwm_addr != cur_addr || iwm_dout != cur_dout) begin
                cur_ok = 1'b0;
            end
            low_run++;
        end else if (low_run != 0) begin
            log_addr.push_back(cur_addr);
            log_dout.push_back(cur_dout);
            log_len.push_back(low_run);
            log_ok.push_back(cur_ok);
            if (cur_addr == 4'hF)      hs_ready = 1'b0;
            else if (cur_addr == 4'hC) hs_ready = 1'b1;
            win_cnt++;
            low_run = 0;
        end
        prev_addr = iwm_addr;
        prev_dout = iwm_dout;
        if (wr_ready)             wr_pulses++;
        if (done)                 done_pulses++;
        if (rd_valid && rd_ready) rd_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for IDLE, then presents a command for exactly one accepting edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [9:0] len);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        cmd_op = op; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // lat counts cycles from the accept edge; 1 means done in the first cycle after it.
    task automatic wait_done(input int budget, output int lat, output bit seen);
        lat = 1;
        while (!done && lat < budget) begin tick(); lat++; end
        seen = done;
    endtask

    function automatic int bad_windows(input int base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (log_len[base + i] != 4 || !log_ok[base + i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        reset = 1'b0;
        tick();
        checks++;
        if (iwm_devsel_n !== 1'b1 || iwm_addr !== 4'h0 || iwm_dout !== 8'h00) begin
            errors++; $display("FAIL reset_iwm got devsel_n=%b addr=%h dout=%h exp 1/0/00", iwm_devsel_n, iwm_addr, iwm_dout);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 2'b00) begin
            errors++; $display("FAIL reset_ctl got ready=%b busy=%b done=%b err=%b exp 1/0/0/00", cmd_ready, busy, done, err);
        end
        checks++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_stream got wr_ready=%b rd_valid=%b rd_data=%h exp 0/0/00", wr_ready, rd_valid, rd_data);
        end
    endtask

    task automatic test_setbit();
        int base, dp, lat;
        bit seen;
        mode = 3; base = win_cnt; dp = done_pulses;
        issue(2'b00, 4'h9, 10'd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL setbit_busy got=%b exp=1", busy); end
        // a second command offered while busy must be ignored
        cmd_op = 2'b00; cmd_addr = 4'h2; cmd_valid = 1'b1;
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        lat = 4;
        while (!done && lat < 50) begin tick(); lat++; end
        seen = done;
        checks++;
        if (!seen || lat != 8) begin errors++; $display("FAIL setbit_latency got=%0d seen=%0b exp=8", lat, seen); end
        checks++;
        if (err !== 2'b00) begin errors++; $display("FAIL setbit_err got=%b exp=00", err); end
        tick(); tick();
        checks++;
        if (win_cnt - base != 1) begin errors++; $display("FAIL setbit_windows got=%0d exp=1", win_cnt - base); end
        checks++;
        if (win_cnt - base >= 1 && (log_addr[base] !== 4'h9 || log_len[base] != 4 || !log_ok[base])) begin
            errors++; $display("FAIL setbit_window got addr=%h len=%0d ok=%0b exp 9/4/1", log_addr[base], log_len[base], log_ok[base]);
        end
        checks++;
        if (done_pulses - dp != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL setbit_done_pulse got=%0d busy=%b exp 1/0", done_pulses - dp, busy);
        end
    endtask

    task automatic test_write();
        logic [7:0] data [3] = '{8'hFF, 8'hD5, 8'hAA};
        logic [3:0] exp_a [14] = '{4'hD, 4'hF, 4'hC, 4'hC, 4'hD, 4'hF, 4'hC, 4'hC,
                                   4'hD, 4'hF, 4'hC, 4'hC, 4'hC, 4'hE};
        int base, wp, idx, lat, n, bad;
        bit pr;
        mode = 0; base = win_cnt; wp = wr_pulses; idx = 0;
        wr_data = data[0]; wr_valid = 1'b1;
        issue(2'b01, 4'h0, 10'd3);
        lat = 1;
        while (!done && lat < 600) begin
            pr = wr_ready;
            tick(); lat++;
            if (pr) begin
                idx++;
                if (idx < 3) wr_data = data[idx];
                else         wr_valid = 1'b0;
            end
        end
        checks++;
        if (!done || err !== 2'b00) begin errors++; $display("FAIL write_done got done=%b err=%b exp 1/00", done, err); end
        checks++;
        if (wr_pulses - wp != 3) begin errors++; $display("FAIL write_wr_ready got=%0d exp=3", wr_pulses - wp); end
        n = win_cnt - base;
        checks++;
        if (n != 14) begin errors++; $display("FAIL write_windows got=%0d exp=14", n); end
        bad = 0;
        for (int i = 0; i < 14; i++)
            if (i >= n || log_addr[base + i] !== exp_a[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL write_order got %0d wrong addresses exp 0", bad); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (n > 4 * k + 1 && log_dout[base + 4 * k + 1] !== data[k]) begin
                errors++; $display("FAIL write_dout%0d got=%h exp=%h", k, log_dout[base + 4 * k + 1], data[k]);
            end
        end
        checks++;
        if (bad_windows(base, n) != 0) begin errors++; $display("FAIL write_timing got %0d bad windows exp 0", bad_windows(base, n)); end
        wr_valid = 1'b0;
    endtask

    task automatic test_underrun();
        logic [3:0] exp_a [4] = '{4'hD, 4'hF, 4'hC, 4'hE};
        int base, wp, lat, n, bad;
        bit seen, pr;
        mode = 1; base = win_cnt; wp = wr_pulses;
        wr_data = 8'h96; wr_valid = 1'b1;
        issue(2'b01, 4'h0, 10'd2);
        lat = 1;
        while (!done && lat < 800) begin
            pr = wr_ready;
            tick(); lat++;
            if (pr) wr_valid = 1'b0;
        end
        seen = done;
        checks++;
        if (!seen || err !== 2'b10) begin errors++; $display("FAIL underrun_err got done=%b err=%b exp 1/10", seen, err); end
        checks++;
        if (wr_pulses - wp != 1) begin errors++; $display("FAIL underrun_wr_ready got=%0d exp=1", wr_pulses - wp); end
        n = win_cnt - base; bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= n || log_addr[base + i] !== exp_a[i]) bad++;
        checks++;
        if (n != 4 || bad != 0) begin errors++; $display("FAIL underrun_order got n=%0d wrong=%0d exp 4/0", n, bad); end
    endtask

    task automatic test_read();
        int base, hs, n, lat, w;
        bit seen, act;
        rd_script = '{8'h00, 8'h00, 8'h00, 8'h55, 8'hD5, 8'h12, 8'hAA, 8'h00};
        base = win_cnt; rd_base = win_cnt; hs = rd_hs; rd_ready = 1'b0; mode = 2;
        issue(2'b10, 4'h0, 10'd2);
        n = 0;
        while (!rd_valid && n < 300) begin tick(); n++; end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hD5) begin
            errors++; $display("FAIL read_first got valid=%b data=%h exp 1/d5", rd_valid, rd_data);
        end
        w = win_cnt; act = 1'b0;
        repeat (100) begin tick(); if (!iwm_devsel_n) act = 1'b1; end
        checks++;
        if (act || win_cnt != w || rd_valid !== 1'b1) begin
            errors++; $display("FAIL read_hold got activity=%0b valid=%b exp 0/1", act, rd_valid);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        n = 0;
        while (!rd_valid && n < 300) begin tick(); n++; end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hAA) begin
            errors++; $display("FAIL read_second got valid=%b data=%h exp 1/aa", rd_valid, rd_data);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        wait_done(20, lat, seen);
        checks++;
        if (!seen || lat != 1 || err !== 2'b00) begin
            errors++; $display("FAIL read_done got seen=%0b lat=%0d err=%b exp 1/1/00", seen, lat, err);
        end
        checks++;
        if (win_cnt - base != 7 || rd_hs - hs != 2 || log_addr[base] !== 4'hE || log_addr[base + 1] !== 4'hC) begin
            errors++; $display("FAIL read_windows got n=%0d hs=%0d first=%h exp 7/2/e", win_cnt - base, rd_hs - hs, log_addr[base]);
        end
    endtask

    task automatic test_timeout();
        int base, lat;
        bit seen;
        mode = 3; base = win_cnt; rd_ready = 1'b1;
        issue(2'b10, 4'h0, 10'd1);
        wait_done(400, lat, seen);
        checks++;
        if (!seen || err !== 2'b01) begin errors++; $display("FAIL timeout_err got seen=%0b err=%b exp 1/01", seen, err); end
        checks++;
        if (win_cnt - base != 18) begin errors++; $display("FAIL timeout_polls got=%0d exp=18 windows", win_cnt - base); end
        rd_ready = 1'b0;
    endtask

    task automatic test_zero_len();
        int base, lat, wp;
        bit seen;
        base = win_cnt; wp = wr_pulses;
        issue(2'b01, 4'h0, 10'd0);
        wait_done(10, lat, seen);
        checks++;
        if (!seen || lat != 1 || err !== 2'b00) begin
            errors++; $display("FAIL wzero got seen=%0b lat=%0d err=%b exp 1/1/00", seen, lat, err);
        end
        issue(2'b10, 4'h0, 10'd0);
        wait_done(10, lat, seen);
        checks++;
        if (!seen || lat != 1 || err !== 2'b00) begin
            errors++; $display("FAIL rzero got seen=%0b lat=%0d err=%b exp 1/1/00", seen, lat, err);
        end
        tick();
        checks++;
        if (win_cnt != base || wr_pulses != wp) begin
            errors++; $display("FAIL zero_activity got windows=%0d wr_ready=%0d exp 0/0", win_cnt - base, wr_pulses - wp);
        end
    endtask

    task automatic test_long_read();
        int base, hs, lat;
        bit seen;
        mode = 4; base = win_cnt; hs = rd_hs; rd_ready = 1'b1;
        issue(2'b10, 4'h0, 10'd1023);
        wait_done(20000, lat, seen);
        checks++;
        if (!seen || err !== 2'b00) begin errors++; $display("FAIL long_done got seen=%0b err=%b exp 1/00", seen, err); end
        checks++;
        if (rd_hs - hs != 1023 || win_cnt - base != 1025) begin
            errors++; $display("FAIL long_count got hs=%0d windows=%0d exp 1023/1025", rd_hs - hs, win_cnt - base);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, dp, w, base, lat;
        bit act, seen;
        mode = 0; wr_data = 8'h3C; wr_valid = 1'b1;
        issue(2'b01, 4'h0, 10'd1);
        n = 0;
        while (iwm_devsel_n && n < 100) begin tick(); n++; end
        checks++;
        if (iwm_devsel_n !== 1'b0) begin errors++; $display("FAIL rmid_window got devsel_n=%b exp 0", iwm_devsel_n); end
        tick();
        reset = 1'b1; wr_valid = 1'b0;
        tick();
        checks++;
        if (iwm_devsel_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_abort got devsel_n=%b busy=%b exp 1/0", iwm_devsel_n, busy);
        end
        reset = 1'b0;
        tick(); tick();
        dp = done_pulses; w = win_cnt; act = 1'b0;
        repeat (30) begin tick(); if (!iwm_devsel_n) act = 1'b1; end
        checks++;
        if (act || win_cnt != w || done_pulses != dp) begin
            errors++; $display("FAIL rmid_quiet got activity=%0b done=%0d exp 0/0", act, done_pulses - dp);
        end
        base = win_cnt;
        issue(2'b00, 4'h9, 10'd0);
        wait_done(50, lat, seen);
        checks++;
        if (!seen || lat != 8 || err !== 2'b00) begin
            errors++; $display("FAIL rmid_setbit got seen=%0b lat=%0d err=%b exp 1/8/00", seen, lat, err);
        end
        tick(); tick();
        checks++;
        if (win_cnt - base != 1 || log_addr[base] !== 4'h9) begin
            errors++; $display("FAIL rmid_setbit_window got n=%0d addr=%h exp 1/9", win_cnt - base, log_addr[base]);
        end
    endtask

    initial begin
        test_reset();
        test_setbit();
        test_write();
        test_underrun();
        test_read();
        test_timeout();
        test_zero_len();
        test_long_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iwm_sequencer.md
Name: iwm_sequencer

Overview:
- Command-driven bus sequencer that owns the IWM host-side access port (A3-A0, /DEVSEL, data in/out) on behalf of the Liron/SmartPort controller logic.
- Turns high-level commands into correctly timed IWM state-bit accesses: set a state bit, write N nibbles with handshake polling, read N nibbles with MSB polling.
- Sits between the packet engine (streams) and the IWM; the IWM Q3 input is tied low, so writes are qualified by /DEVSEL alone.

Parameters:
- ACCESS_CYCLES, 4: clk cycles /DEVSEL is held low per access; minimum 2.
- GAP_CYCLES, 2: clk cycles /DEVSEL is held high between accesses; minimum 1.
- TIMEOUT_POLLS, 16'd40000: maximum consecutive unsuccessful polls before the command aborts.

Ports:
- clk  in  1  system clock, same clock as the IWM fclk.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_op  in  2  00 = SETBIT, 01 = WRITE, 10 = READ, 11 = reserved (treated as SETBIT).
- cmd_addr  in  4  SETBIT address (A3-A1 = state bit, A0 = value).
- cmd_len  in  10  WRITE/READ nibble count; 0 is legal.
- wr_data  in  8  nibble to write.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  one-cycle pulse when wr_data is consumed.
- rd_data  out  8  nibble read.
- rd_valid  out  1  held until rd_ready.
- rd_ready  in  1  consumer accepts.
- done  out  1  one-cycle pulse at command end.
- err  out  2  valid with done and held until the next command: 00 ok, 01 timeout, 10 underrun.
- busy  out  1  high when not in IDLE.
- iwm_addr  out  4  IWM A3-A0.
- iwm_devsel_n  out  1  IWM /DEVSEL.
- iwm_dout  out  8  to IWM dataIn.
- iwm_din  in  8  from IWM dataOut.

Behaviour:
- Reset values: iwm_devsel_n=1, iwm_addr=0, iwm_dout=0, cmd_ready=0 during reset, then 1. wr_ready=0, rd_valid=0, rd_data=0, done=0, err=00, busy=0. FSM=IDLE, counters=0.
- Reset mid-operation: iwm_devsel_n is 1 on the cycle after reset is sampled. No further access occurs, and no done is issued.
- Access primitive ACC(a, d):
  - Cycle 0: iwm_addr=a, iwm_dout=d, /DEVSEL high (setup).
  - Cycles 1..ACCESS_CYCLES: /DEVSEL low.
  - iwm_din is sampled on the last low cycle.
  - Then GAP_CYCLES high; the next access may begin after the gap.
  - iwm_addr and iwm_dout stay stable throughout setup and the low window.
- Command acceptance: on cmd_valid & cmd_ready, the command is latched and busy rises on the next cycle.
- SETBIT: ACC(cmd_addr, 0), then done with err=00. Command-to-done latency is 1+ACCESS_CYCLES+GAP_CYCLES+1 cycles.
- WRITE, cmd_len=0: done with err=00 one cycle after accept; no IWM access.
- WRITE sequence:
  - W_LOAD0: wait for wr_valid, then ACC(0xD) to set Q6, then ACC(0xF, wr_data) to set Q7 and load. wr_ready pulses at the end of that access.
  - W_POLL: ACC(0xC) reads the handshake register.
    - bit6=0: underrun. Go to W_END with err=10.
    - bit6=1, bit7=0: poll count +1. Re-poll, or go to W_END with err=01 when the count reaches TIMEOUT_POLLS.
    - bit6=1, bit7=1: if more nibbles remain, go to W_NEXT; otherwise go to W_DRAIN.
  - W_NEXT: wait for wr_valid (/DEVSEL stays high while waiting), then ACC(0xD), then ACC(0xF, wr_data), pulse wr_ready, decrement the remaining count, and return to W_POLL.
  - W_DRAIN: one further poll with bit7=1 confirms the shifter has taken the last nibble, then go to W_END.
  - W_END: ACC(0xE) clears Q7, then DONE.
  - The poll counter resets on each successful poll.
- READ, cmd_len=0: done with err=00 one cycle after accept; no IWM access.
- READ sequence:
  - ACC(0xE) clears Q7, then ACC(0xC) clears Q6, selecting the data register.
  - R_POLL: ACC(0xC).
    - din[7]=1: rd_data=din, rd_valid=1, go to R_PUSH.
    - Otherwise: poll count +1; at TIMEOUT_POLLS go to DONE with err=01.
  - R_PUSH: hold rd_valid until rd_ready, with no IWM accesses. On the handshake, decrement the remaining count. Return to R_POLL, or go to DONE when the count reaches 0.
- DONE: done=1 for one cycle, err is updated, return to IDLE.
- Boundaries:
  - A wr_valid gap longer than one IWM byte time produces a real underrun, detected at the next poll.
  - cmd_valid while busy is ignored.
  - The remaining count is 10 bits; cmd_len=1023 must complete.

Test Plan:
- SETBIT cmd_addr=0x9 (motor on) -> one /DEVSEL low window of 4 cycles with iwm_addr=9; done 8 cycles after accept; err=00; IWM _enbl1=0.
- WRITE len=3, data 0xFF,0xD5,0xAA, IWM motor on, wr_valid always high -> access order D,F(FF),C.., D,F(D5),C.., D,F(AA),C.., C, E; 3 wr_ready pulses; err=00; IWM wrdata toggles match the bits.
- WRITE len=2 with wr_valid dropped for 600 cycles after the first nibble -> poll returns bit6=0; ACC(0xE) issued; err=10; only 1 wr_ready.
- READ len=2 with rddata pulses encoding 0xD5,0xAA and rd_ready held low 100 cycles on the first nibble -> rd_data 0xD5 then 0xAA; no /DEVSEL activity while rd_valid is pending; err=00.
- READ len=1 with no rddata activity, TIMEOUT_POLLS=16 -> exactly 16 polls after the E,C setup, then done with err=01.
- Reset asserted during the /DEVSEL low window of a WRITE -> iwm_devsel_n=1 next cycle; busy=0; no done; the next SETBIT command runs normally.
